tdm_demux_frame: RTL
====================

Name: tdm_demux_frame

Overview:
- Receive-side counterpart of the team's select-driven multiplexers: consumes a time-division-multiplexed sample stream (one channel sample per accepted beat, channel 0 flagged by start-of-frame) and demultiplexes it into NUM_CH parallel channel registers.
- Internally tracks the channel index (the "sel" the transmitting mux used), double-buffers a frame, and publishes all channels atomically with a one-cycle valid pulse.
- Sits between a serialised link and parallel consumers (e.g. a 16-channel bit/byte bank).

Parameters:
- NUM_CH, 16, number of channels per frame (>=2).
- DATA_W, 8, width of one channel sample in bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample beat present this cycle.
- in_sof  input  1  beat is channel 0 of a frame; ignored when in_valid=0.
- in_data  input  DATA_W  sample value.
- out_data  output  NUM_CH*DATA_W  published frame; channel k at bits [k*DATA_W +: DATA_W].
- out_valid  output  1  one-cycle pulse when out_data updates.
- ch_idx  output  clog2(NUM_CH)  channel index expected for the next beat.
- locked  output  1  high while in RECV state.
- sync_err  output  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (rst=1 at edge): state=HUNT, ch_idx=0, out_data=0, shadow=0, out_valid=0, sync_err=0, locked=0. rst has priority over all inputs. Reset mid-frame discards the partial frame; out_data is cleared.
- No backpressure: every beat with in_valid=1 is accepted. in_valid=0 cycles are gaps; state, ch_idx and shadow hold.
- HUNT:
  - in_valid & in_sof: shadow[0]<=in_data, ch_idx<=1, go RECV.
  - Any other beat: discarded; no sync_err.
- RECV, on in_valid=1:
  - in_sof & ch_idx!=0: sync_err pulse; partial frame discarded; beat treated as new channel 0 (shadow[0]<=in_data, ch_idx<=1, stay RECV).
  - !in_sof & ch_idx==0: sync_err pulse; beat discarded; go HUNT, ch_idx<=0.
  - Otherwise: shadow[ch_idx]<=in_data. If ch_idx==NUM_CH-1, out_data<={in_data, shadow[NUM_CH-2:0]} (last sample bypasses shadow), out_valid pulses, ch_idx<=0; else ch_idx<=ch_idx+1.
- Latency: out_valid and new out_data are visible the cycle after the edge that accepts the last sample of the frame. out_data holds until the next complete frame; partial frames never reach out_data.
- Back-to-back frames: a last-sample beat followed immediately by an SOF beat is legal at full rate, with no dead cycle. out_valid can pulse every NUM_CH accepted beats.
- Wrap-around: ch_idx wraps from NUM_CH-1 to 0 only on accepting the last sample. It never takes values >= NUM_CH.
- locked = (state==RECV), registered. sync_err and out_valid are registered, never high in the cycle after reset.
- Simultaneous events: an SOF beat that completes a frame cannot occur (SOF always implies index 0). When sync_err fires, out_valid is 0 in that same cycle.

Decomposition:
- Package tdm_pkg: state enum {HUNT, RECV}; function/constant CH_IDX_W = $clog2(NUM_CH); helper to slice a channel from the flat bus.
- One natural sub-module: tdm_ch_counter. It holds the modulo-NUM_CH index with load-to-1, clear and increment controls, and a terminal-count output. The top level holds the FSM, shadow registers and output register.

Test Plan:
- Reset, then a clean frame (NUM_CH=16, DATA_W=8): beats 0..15 with in_data=8'h10+k, SOF on beat 0 -> out_valid one pulse one cycle after beat 15; out_data channel k = 8'h10+k; locked=1 from the cycle after beat 0.
- Two frames back-to-back with no gaps, second frame data 8'hA0+k -> two out_valid pulses exactly 16 cycles apart; out_data holds frame-1 values until the second pulse.
- Gaps: random in_valid=0 cycles inserted inside a frame -> same out_data as the clean case; ch_idx frozen across gaps; no sync_err.
- Early SOF after 5 beats (in_data=8'h55), then a full frame -> one sync_err pulse; out_data excludes 8'h55 unless it restarts channel 0; a single out_valid after the completed frame.
- Missing SOF: a frame ends, then a beat arrives with in_sof=0 -> sync_err pulse, locked falls to 0, next non-SOF beats ignored, relock on the next SOF.
- rst asserted for one cycle at beat 9 of a frame -> out_data=0, ch_idx=0, locked=0; no out_valid until a fresh complete frame.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM frame demultiplexer.
package tdm_pkg;

  // Receiver framing state: HUNT waits for a start-of-frame, RECV collects samples.
  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  // Default geometry: a 16-channel byte bank.
  localparam int NUM_CH_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Width of the channel index for a frame of n channels.
  function automatic int ch_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Extract channel k from a flat frame bus of the default geometry.
  function automatic logic [DATA_W_DEF-1:0] ch_slice(
    input logic [NUM_CH_DEF*DATA_W_DEF-1:0] bus,
    input int k
  );
    return bus[k*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/tdm_demux_frame_if.sv
// Stream-in / frame-out bundle of the TDM demultiplexer.
// Handshake: there is no ready. Every cycle with in_valid=1 is one accepted
// beat; in_sof and in_data are only meaningful while in_valid=1. On the
// output side out_valid is a one-cycle pulse marking the cycle in which
// out_data first shows a new frame; out_data then holds until the next pulse.
interface tdm_demux_frame_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8
);

  localparam int CH_IDX_W = tdm_pkg::ch_idx_w(NUM_CH);

  logic                     in_valid;
  logic                     in_sof;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_valid;
  logic [CH_IDX_W-1:0]      ch_idx;
  logic                     locked;
  logic                     sync_err;
  tdm_pkg::tdm_state_e      state;

  // Source side: the serial link feeding samples, observing the frame.
  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, ch_idx, locked, sync_err, state
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, ch_idx, locked, sync_err, state
  );

endinterface

// File: rtl/tdm_ch_counter.sv
// Modulo-NUM_CH channel index with clear, load-to-1 and increment controls.
module tdm_ch_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        load1,
  input  logic                        inc,
  output logic [ch_idx_w(NUM_CH)-1:0] idx,
  output logic                        tc
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);
  localparam logic [CH_IDX_W-1:0] LAST = CH_IDX_W'(NUM_CH - 1);
  localparam logic [CH_IDX_W-1:0] ONE  = CH_IDX_W'(1);

  logic [CH_IDX_W-1:0] idx_q;

  // Index register: clear beats load, load beats increment; wraps only at LAST.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_q <= '0;
    end else if (load1) begin
      idx_q <= ONE;
    end else if (inc) begin
      idx_q <= (idx_q == LAST) ? '0 : idx_q + ONE;
    end
  end

  assign idx = idx_q;
  assign tc  = (idx_q == LAST);

endmodule

// File: rtl/tdm_demux_frame.sv
// TDM frame demultiplexer: collects one sample per accepted beat into a
// shadow frame and publishes all channels at once when the frame completes.
module tdm_demux_frame
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  tdm_demux_frame_if.slave  bus
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);
  localparam int SH_W     = (NUM_CH - 1) * DATA_W;

  tdm_state_e state_q, state_d;

  logic [CH_IDX_W-1:0] idx;
  logic [CH_IDX_W-1:0] sh_idx;
  logic                tc;
  logic                ctr_clr, ctr_load1, ctr_inc;
  logic                sh_we, publish, err_d;

  // Channels 0..NUM_CH-2 only: the last sample goes straight to the output.
  logic [SH_W-1:0]          shadow_q;
  logic [NUM_CH*DATA_W-1:0] out_data_q;
  logic                     out_valid_q, sync_err_q;

  tdm_ch_counter #(.NUM_CH(NUM_CH)) u_ch_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .idx   (idx),
    .tc    (tc)
  );

  // Framing decisions for the current beat: next state, index control, writes.
  always_comb begin
    state_d   = state_q;
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;
    sh_we     = 1'b0;
    publish   = 1'b0;
    err_d     = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            sh_we     = 1'b1;
            ctr_load1 = 1'b1;
            state_d   = RECV;
          end
        end
        RECV: begin
          if (bus.in_sof && (idx != '0)) begin
            // Early SOF: drop the partial frame and restart at channel 0.
            err_d     = 1'b1;
            sh_we     = 1'b1;
            ctr_load1 = 1'b1;
          end else if (!bus.in_sof && (idx == '0)) begin
            // Expected a frame start and did not get one: lose lock.
            err_d     = 1'b1;
            ctr_clr   = 1'b1;
            state_d   = HUNT;
          end else begin
            sh_we     = 1'b1;
            ctr_inc   = 1'b1;
            publish   = tc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A restarting SOF always lands in channel 0 regardless of the old index.
  assign sh_idx = ctr_load1 ? '0 : idx;

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow frame capture for all but the last channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (sh_we && !publish) begin
      shadow_q[int'(sh_idx)*DATA_W +: DATA_W] <= bus.in_data;
    end
  end

  // Output frame register and the registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      out_valid_q <= publish;
      sync_err_q  <= err_d;
      if (publish) begin
        out_data_q <= {bus.in_data, shadow_q};
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.ch_idx    = idx;
  assign bus.locked    = (state_q == RECV);
  assign bus.state     = state_q;

endmodule
